// File: rtl/ofdm_pkg.sv
// Shared OFDM transmit-chain constants and the cyclic-prefix read-FSM state encoding.
package ofdm_pkg;

  localparam int N_FFT    = 64;
  localparam int LOG2_N   = 6;
  localparam int CP_LEN   = 16;
  localparam int SAMPLE_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PFX  = 2'd1,
    BODY = 2'd2
  } rd_state_e;

endpackage

// File: rtl/cp_insert_if.sv
// Sample-stream bundle of the cyclic-prefix inserter: IFFT samples in, prefixed symbols out.
interface cp_insert_if
  import ofdm_pkg::*;
#(
   parameter int WIDTH = SAMPLE_W
);

   logic             ena_in;
   logic [WIDTH-1:0] dat_in;
   logic             in_rdy;
   logic             val_out;
   logic             sym_sta;
   logic [WIDTH-1:0] dat_out;

   modport master (
      output ena_in, dat_in,
      input  in_rdy, val_out, sym_sta, dat_out
   );

   modport slave (
      input  ena_in, dat_in,
      output in_rdy, val_out, sym_sta, dat_out
   );

endinterface

// File: rtl/cp_ram.sv
// Ping-pong symbol store: simple dual-port RAM holding two N-sample banks, registered read.
module cp_ram
  import ofdm_pkg::*;
#(
   parameter int WIDTH = SAMPLE_W,
   parameter int N     = N_FFT,
   parameter int B     = LOG2_N
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [B:0]       wa,
   input  logic [WIDTH-1:0] wd,
   input  logic             re,
   input  logic [B:0]       ra,
   output logic [WIDTH-1:0] rd
);

   localparam int DEPTH = 2 * N;

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: the array is left without reset so it maps onto block RAM; only the read register is reset.
   always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
   end

   // The read register doubles as the output register and holds its value while re is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)    rd <= '0;
      else if (re) rd <= mem[ra];
   end

endmodule

// File: rtl/cp_insert.sv
// Transmit-side cyclic-prefix inserter: buffers each IFFT symbol in a ping-pong RAM and
// replays its last CP samples followed by the whole symbol.
module cp_insert
  import ofdm_pkg::*;
#(
   parameter int WIDTH = SAMPLE_W,
   parameter int N     = N_FFT,
   parameter int B     = LOG2_N,
   parameter int CP    = CP_LEN
) (
   input logic        clk,
   input logic        rst,
   cp_insert_if.slave sif
);

   if (CP < 1 || CP > N - 1) begin : g_bad_cp
      $error("cp_insert: CP must lie in 1..N-1");
   end
   if ((N & (N - 1)) != 0 || (1 << B) != N) begin : g_bad_n
      $error("cp_insert: N must be a power of two equal to 2**B");
   end

   localparam logic [B-1:0] ADR_LAST  = B'(N - 1);
   localparam logic [B-1:0] PFX_START = B'(N - CP);

   // write side
   logic [B-1:0] wr_adr, wr_adr_nxt;
   logic         wr_bank, wr_bank_nxt;
   logic         wr_acc, set_full;

   // bank occupancy and read side
   logic [1:0]   full, full_nxt;
   rd_state_e    state, state_nxt;
   logic [B-1:0] rd_adr, rd_adr_nxt;
   logic         rd_bank, rd_bank_nxt;
   logic         clr_full, rd_en_nxt, sta_nxt;

   logic         in_rdy_q, val_q, sta_q;

   assign wr_acc = sif.ena_in && in_rdy_q;

   // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      wr_adr_nxt  = wr_adr;
      wr_bank_nxt = wr_bank;
      set_full    = 1'b0;
      if (wr_acc) begin
         wr_adr_nxt = wr_adr + B'(1);
         if (wr_adr == ADR_LAST) begin
            set_full    = 1'b1;
            wr_bank_nxt = ~wr_bank;
         end
      end
   end

   // The registered state/address describe the sample on dat_out; the RAM is read with the
   // next-state address so the first prefix sample appears two cycles after the last input.
   always_comb begin
      state_nxt   = state;
      rd_adr_nxt  = rd_adr;
      rd_bank_nxt = rd_bank;
      clr_full    = 1'b0;
      case (state)
         IDLE: begin
            if (full[rd_bank]) begin
               state_nxt  = PFX;
               rd_adr_nxt = PFX_START;
            end
         end
         PFX: begin
            rd_adr_nxt = rd_adr + B'(1);
            if (rd_adr == ADR_LAST) state_nxt = BODY;
         end
         BODY: begin
            rd_adr_nxt = rd_adr + B'(1);
            if (rd_adr == ADR_LAST) begin
               clr_full    = 1'b1;
               rd_bank_nxt = ~rd_bank;
               if (full[~rd_bank]) begin
                  state_nxt  = PFX;
                  rd_adr_nxt = PFX_START;
               end else begin
                  state_nxt  = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Banks alternate, so a set and a clear never target the same flag in one cycle.
   always_comb begin
      full_nxt = full;
      if (set_full) full_nxt[wr_bank] = 1'b1;
      if (clr_full) full_nxt[rd_bank] = 1'b0;
   end

   assign rd_en_nxt = (state_nxt != IDLE);
   assign sta_nxt   = (state_nxt == PFX) && (state != PFX);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_adr   <= '0;
         wr_bank  <= 1'b0;
         full     <= 2'b00;
         in_rdy_q <= 1'b0;
      end else begin
         wr_adr   <= wr_adr_nxt;
         wr_bank  <= wr_bank_nxt;
         full     <= full_nxt;
         in_rdy_q <= ~full_nxt[wr_bank_nxt];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         rd_adr  <= '0;
         rd_bank <= 1'b0;
         val_q   <= 1'b0;
         sta_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         rd_adr  <= rd_adr_nxt;
         rd_bank <= rd_bank_nxt;
         val_q   <= rd_en_nxt;
         sta_q   <= sta_nxt;
      end
   end

   cp_ram #(
      .WIDTH (WIDTH),
      .N     (N),
      .B     (B)
   ) u_ram (
      .clk (clk),
      .rst (rst),
      .we  (wr_acc),
      .wa  ({wr_bank, wr_adr}),
      .wd  (sif.dat_in),
      .re  (rd_en_nxt),
      .ra  ({rd_bank_nxt, rd_adr_nxt}),
      .rd  (sif.dat_out)
   );

   assign sif.in_rdy  = in_rdy_q;
   assign sif.val_out = val_q;
   assign sif.sym_sta = sta_q;

endmodule

// File: tb/tb_cp_insert.sv
// Directed bench for cp_insert: single symbol, back-to-back stream, random input gaps,
// mid-prefix reset, and CP=1 / CP=N-1 builds.
module tb_cp_insert;
   import ofdm_pkg::*;

   localparam int W = SAMPLE_W;
   localparam int N = N_FFT;
   localparam int B = LOG2_N;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cp_insert_if #(.WIDTH(W)) bus ();
   cp_insert_if #(.WIDTH(W)) bus_c1 ();
   cp_insert_if #(.WIDTH(W)) bus_c63 ();

   cp_insert #(.WIDTH(W), .N(N), .B(B), .CP(16)) dut     (.clk(clk), .rst(rst), .sif(bus));
   cp_insert #(.WIDTH(W), .N(N), .B(B), .CP(1))  dut_c1  (.clk(clk), .rst(rst), .sif(bus_c1));
   cp_insert #(.WIDTH(W), .N(N), .B(B), .CP(63)) dut_c63 (.clk(clk), .rst(rst), .sif(bus_c63));

   // Output capture for the CP=16 instance: samples, their cycles, sym_sta positions, burst lengths.
   logic [W-1:0] q0[$];
   int cyc0[$], sta0[$], runs0[$];
   int run0 = 0;
   int stray0 = 0;
   always @(negedge clk) begin
      if (bus.val_out) begin
         if (bus.sym_sta) sta0.push_back(q0.size());
         q0.push_back(bus.dat_out);
         cyc0.push_back(cyc);
         run0++;
      end else begin
         if (bus.sym_sta) stray0++;
         if (run0 > 0) begin
            runs0.push_back(run0);
            run0 = 0;
         end
      end
   end

   logic [W-1:0] q1[$], q63[$];
   int cyc1[$], sta1[$], cyc63[$], sta63[$];
   always @(negedge clk) begin
      if (bus_c1.val_out) begin
         if (bus_c1.sym_sta) sta1.push_back(q1.size());
         q1.push_back(bus_c1.dat_out);
         cyc1.push_back(cyc);
      end
      if (bus_c63.val_out) begin
         if (bus_c63.sym_sta) sta63.push_back(q63.size());
         q63.push_back(bus_c63.dat_out);
         cyc63.push_back(cyc);
      end
   end

   int stall_cycles;
   int rdy_rise_cyc;
   int last_acc_cyc;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      q0.delete(); cyc0.delete(); sta0.delete(); runs0.delete();
      run0 = 0; stray0 = 0;
   endtask

   // Present one sample and hold it until in_rdy is seen; returns on the negedge before the accepting edge.
   task automatic push(input logic [W-1:0] v, input bit rnd);
      int guard;
      guard = 0;
      if (rnd) begin
         while ($urandom_range(0, 1) == 0 && guard < 8) begin
            @(negedge clk);
            bus.ena_in = 1'b0;
            guard++;
         end
      end
      @(negedge clk);
      bus.ena_in = 1'b1;
      bus.dat_in = v;
      guard = 0;
      while (!bus.in_rdy && guard < 1000) begin
         stall_cycles++;
         @(negedge clk);
         guard++;
         if (bus.in_rdy && rdy_rise_cyc < 0) rdy_rise_cyc = cyc;
      end
      if (guard >= 1000) check("in_rdy timeout", 64'd0, 64'd1);
      last_acc_cyc = cyc;
   endtask

   task automatic idle_in();
      @(negedge clk);
      bus.ena_in = 1'b0;
   endtask

   task automatic wait_q0(input int n);
      int g;
      g = 0;
      while (q0.size() < n && g < 3000) begin
         @(negedge clk);
         g++;
      end
      repeat (4) @(negedge clk);
   endtask

   function automatic logic [W-1:0] exp_cp16(input int base, input int j);
      return W'(base + ((j < 16) ? (48 + j) : (j - 16)));
   endfunction

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.ena_in = 1'b0;     bus.dat_in = '0;
      bus_c1.ena_in = 1'b0;  bus_c1.dat_in = '0;
      bus_c63.ena_in = 1'b0; bus_c63.dat_in = '0;
      stall_cycles = 0;
      rdy_rise_cyc = -1;
      last_acc_cyc = 0;

      // Reset state
      #3 rst = 1'b0;
      repeat (3) @(negedge clk);
      check("reset in_rdy",  64'(bus.in_rdy),  64'd0);
      check("reset val_out", 64'(bus.val_out), 64'd0);
      check("reset sym_sta", 64'(bus.sym_sta), 64'd0);
      check("reset dat_out", 64'(bus.dat_out), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      check("in_rdy after release", 64'(bus.in_rdy), 64'd1);
      clear_mon();

      // 1: single symbol, continuous input
      for (int i = 0; i < N; i++) push(W'(i), 1'b0);
      idle_in();
      wait_q0(80);
      check("s1 count", 64'(q0.size()), 64'd80);
      for (int j = 0; j < 80 && j < q0.size(); j++)
         check($sformatf("s1 dat[%0d]", j), 64'(q0[j]), 64'(exp_cp16(0, j)));
      check("s1 sym_sta count", 64'(sta0.size()), 64'd1);
      if (sta0.size() > 0) check("s1 sym_sta pos", 64'(sta0[0]), 64'd0);
      if (cyc0.size() > 0) check("s1 latency", 64'(cyc0[0] - last_acc_cyc), 64'd2);
      check("s1 bursts", 64'(runs0.size()), 64'd1);
      if (runs0.size() > 0) check("s1 burst len", 64'(runs0[0]), 64'd80);
      check("s1 stray sym_sta", 64'(stray0), 64'd0);

      // 2: four back-to-back symbols
      clear_mon();
      stall_cycles = 0;
      rdy_rise_cyc = -1;
      for (int k = 0; k < 4; k++)
         for (int i = 0; i < N; i++) push(W'(k * 64 + i), 1'b0);
      idle_in();
      wait_q0(320);
      check("s2 in_rdy dropped", 64'(stall_cycles > 0), 64'd1);
      check("s2 count", 64'(q0.size()), 64'd320);
      for (int j = 0; j < 320 && j < q0.size(); j++)
         check($sformatf("s2 dat[%0d]", j), 64'(q0[j]), 64'(exp_cp16((j / 80) * 64, j % 80)));
      check("s2 bursts", 64'(runs0.size()), 64'd1);
      if (runs0.size() > 0) check("s2 burst len", 64'(runs0[0]), 64'd320);
      check("s2 sym_sta count", 64'(sta0.size()), 64'd4);
      for (int k = 0; k < 4 && k < sta0.size(); k++)
         check($sformatf("s2 sym_sta[%0d]", k), 64'(sta0[k]), 64'(k * 80));
      if (cyc0.size() >= 80) check("s2 in_rdy release cycle", 64'(rdy_rise_cyc), 64'(cyc0[79] + 1));

      // 3: random input gaps, two symbols 0..63
      clear_mon();
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < N; i++) push(W'(i), 1'b1);
      idle_in();
      wait_q0(160);
      check("s3 count", 64'(q0.size()), 64'd160);
      for (int j = 0; j < 160 && j < q0.size(); j++)
         check($sformatf("s3 dat[%0d]", j), 64'(q0[j]), 64'(exp_cp16(0, j % 80)));
      for (int r = 0; r < runs0.size(); r++)
         check($sformatf("s3 burst %0d len mod 80", r), 64'(runs0[r] % 80), 64'd0);
      check("s3 sym_sta count", 64'(sta0.size()), 64'd2);
      for (int k = 0; k < 2 && k < sta0.size(); k++)
         check($sformatf("s3 sym_sta[%0d]", k), 64'(sta0[k]), 64'(k * 80));

      // 4: reset during the prefix, with a partial next symbol buffered
      clear_mon();
      for (int i = 0; i < N; i++) push(W'(100 + i), 1'b0);
      for (int i = 0; i < 3; i++) push(W'(300 + i), 1'b0);
      idle_in();
      begin
         int g;
         g = 0;
         while (q0.size() < 5 && g < 200) begin
            @(negedge clk);
            g++;
         end
      end
      check("s4 pre-reset val_out", 64'(bus.val_out), 64'd1);
      #2 rst = 1'b0;
      #1;
      check("s4 async val_out", 64'(bus.val_out), 64'd0);
      check("s4 async in_rdy",  64'(bus.in_rdy),  64'd0);
      check("s4 async sym_sta", 64'(bus.sym_sta), 64'd0);
      @(negedge clk);
      clear_mon();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < N; i++) push(W'(200 + i), 1'b0);
      idle_in();
      wait_q0(80);
      check("s4 count", 64'(q0.size()), 64'd80);
      for (int j = 0; j < 80 && j < q0.size(); j++)
         check($sformatf("s4 dat[%0d]", j), 64'(q0[j]), 64'(exp_cp16(200, j)));
      check("s4 bursts", 64'(runs0.size()), 64'd1);
      check("s4 sym_sta count", 64'(sta0.size()), 64'd1);
      if (sta0.size() > 0) check("s4 sym_sta pos", 64'(sta0[0]), 64'd0);

      // 5: CP=1 and CP=63 builds, one symbol 0..63 into both
      @(negedge clk);
      check("s5 c1 in_rdy",  64'(bus_c1.in_rdy),  64'd1);
      check("s5 c63 in_rdy", 64'(bus_c63.in_rdy), 64'd1);
      for (int i = 0; i < N; i++) begin
         if (i > 0) @(negedge clk);
         bus_c1.ena_in = 1'b1;  bus_c1.dat_in = W'(i);
         bus_c63.ena_in = 1'b1; bus_c63.dat_in = W'(i);
      end
      last_acc_cyc = cyc;
      @(negedge clk);
      bus_c1.ena_in = 1'b0;
      bus_c63.ena_in = 1'b0;
      begin
         int g;
         g = 0;
         while ((q1.size() < 65 || q63.size() < 127) && g < 400) begin
            @(negedge clk);
            g++;
         end
      end
      repeat (4) @(negedge clk);
      check("s5 c1 count", 64'(q1.size()), 64'd65);
      for (int j = 0; j < 65 && j < q1.size(); j++)
         check($sformatf("s5 c1 dat[%0d]", j), 64'(q1[j]), 64'((j == 0) ? 63 : j - 1));
      check("s5 c1 sym_sta count", 64'(sta1.size()), 64'd1);
      if (sta1.size() > 0) check("s5 c1 sym_sta pos", 64'(sta1[0]), 64'd0);
      if (cyc1.size() > 0) check("s5 c1 latency", 64'(cyc1[0] - last_acc_cyc), 64'd2);
      check("s5 c63 count", 64'(q63.size()), 64'd127);
      for (int j = 0; j < 127 && j < q63.size(); j++)
         check($sformatf("s5 c63 dat[%0d]", j), 64'(q63[j]), 64'((j < 63) ? j + 1 : j - 63));
      check("s5 c63 sym_sta count", 64'(sta63.size()), 64'd1);
      if (sta63.size() > 0) check("s5 c63 sym_sta pos", 64'(sta63[0]), 64'd0);
      if (cyc63.size() > 0) check("s5 c63 latency", 64'(cyc63[0] - last_acc_cyc), 64'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
